// File: rtl/sw_cond_pkg.sv
// Shared definitions for the switch/key input conditioner: key FSM states
// and debounce window constants.
package sw_cond_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        PRESSED = 2'd2,
        RELEASE = 2'd3
    } key_state_e;

    // 10 ms window at 50 MHz
    localparam int unsigned DEBOUNCE_50MHZ = 500000;
    localparam int unsigned SIM_DEBOUNCE   = 4;

endpackage

// File: rtl/sw_key_conditioner_sync2.sv
// Two-flop synchroniser for asynchronous inputs, with a per-instance reset
// value so idle-high signals do not read as active straight out of reset.
module sync2 #(
    parameter int unsigned   W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sw_key_conditioner.sv
// Synchronises and debounces slide switches and an active-low pushbutton;
// emits one load strobe per genuine press and snapshots the switches on it.
module sw_key_conditioner
    import sw_cond_pkg::*;
#(
    parameter int unsigned N               = 8,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_50MHZ,
    parameter int unsigned CNT_W           = 20
) (
    input  logic         Clk,
    input  logic         Resetn,
    input  logic [N-1:0] sw_raw,
    input  logic         key_raw,
    output logic [N-1:0] d_out,
    output logic         load_pulse,
    output logic [N-1:0] held_q,
    output logic [3:0]   press_count,
    output logic         key_level
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0] sw_s;
    logic         key_s;

    sync2 #(.W(N), .RST_VAL({N{1'b0}})) u_sw_sync (
        .clk_i  (Clk),
        .rst_ni (Resetn),
        .d_i    (sw_raw),
        .q_o    (sw_s)
    );

    sync2 #(.W(1), .RST_VAL(1'b1)) u_key_sync (
        .clk_i  (Clk),
        .rst_ni (Resetn),
        .d_i    (key_raw),
        .q_o    (key_s)
    );

    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             tick;
    logic [N-1:0]     snap_q, snap_d;
    logic [N-1:0]     dout_q, dout_d;

    // A switch value must match across two consecutive ticks to be accepted.
    always_comb begin
        tick   = (tcnt_q == LAST);
        tcnt_d = tick ? '0 : tcnt_q + 1'b1;
        snap_d = snap_q;
        dout_d = dout_q;
        if (tick) begin
            snap_d = sw_s;
            if (sw_s == snap_q) begin
                dout_d = sw_s;
            end
        end
    end

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] kcnt_q, kcnt_d;
    logic             pulse_q, pulse_d;
    logic [N-1:0]     hold_q, hold_d;
    logic [3:0]       cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        kcnt_d  = kcnt_q;
        pulse_d = 1'b0;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (!key_s) begin
                    state_d = ARM;
                    kcnt_d  = '0;
                end
            end
            ARM: begin
                if (key_s) begin
                    state_d = IDLE;
                end else if (kcnt_q == LAST) begin
                    // Snapshot takes the registered d_out, not this cycle's update.
                    state_d = PRESSED;
                    pulse_d = 1'b1;
                    hold_d  = dout_q;
                    cnt_d   = cnt_q + 4'd1;
                end else begin
                    kcnt_d = kcnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (key_s) begin
                    state_d = RELEASE;
                    kcnt_d  = '0;
                end
            end
            RELEASE: begin
                if (!key_s) begin
                    state_d = PRESSED;
                end else if (kcnt_q == LAST) begin
                    state_d = IDLE;
                end else begin
                    kcnt_d = kcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            tcnt_q  <= '0;
            snap_q  <= '0;
            dout_q  <= '0;
            state_q <= IDLE;
            kcnt_q  <= '0;
            pulse_q <= 1'b0;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            tcnt_q  <= tcnt_d;
            snap_q  <= snap_d;
            dout_q  <= dout_d;
            state_q <= state_d;
            kcnt_q  <= kcnt_d;
            pulse_q <= pulse_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    assign d_out       = dout_q;
    assign load_pulse  = pulse_q;
    assign held_q      = hold_q;
    assign press_count = cnt_q;
    assign key_level   = (state_q == PRESSED) || (state_q == RELEASE);

endmodule

// File: tb/tb_sw_key_conditioner.sv
// Self-checking bench for sw_key_conditioner with a 4-cycle debounce window.
module tb_sw_key_conditioner;
    import sw_cond_pkg::*;

    logic       Clk = 1'b0;
    logic       Resetn = 1'b0;
    logic [7:0] sw_raw = 8'h00;
    logic       key_raw = 1'b1;
    logic [7:0] d_out;
    logic       load_pulse;
    logic [7:0] held_q;
    logic [3:0] press_count;
    logic       key_level;

    sw_key_conditioner #(
        .N               (8),
        .DEBOUNCE_CYCLES (SIM_DEBOUNCE),
        .CNT_W           (4)
    ) dut (
        .Clk         (Clk),
        .Resetn      (Resetn),
        .sw_raw      (sw_raw),
        .key_raw     (key_raw),
        .d_out       (d_out),
        .load_pulse  (load_pulse),
        .held_q      (held_q),
        .press_count (press_count),
        .key_level   (key_level)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] held;
        logic [3:0] count;
    } exp_t;

    typedef struct {
        logic [7:0] sw;
        logic [7:0] dout;
        logic [7:0] held;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    int   pulses = 0;
    logic prev_pulse = 1'b0;
    exp_t sb[$];
    exp_t mon_e;
    logic [3:0] exp_count = 4'd0;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (load_pulse === 1'b1) begin
            pulses++;
            check("pulse_width", {31'd0, prev_pulse}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_held_q", {24'd0, held_q}, {24'd0, mon_e.held});
                check("sb_press_count", {28'd0, press_count}, {28'd0, mon_e.count});
            end
        end
        prev_pulse = load_pulse;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic expect_press(input logic [7:0] h);
        exp_count = 4'(exp_count + 4'd1);
        sb.push_back('{held: h, count: exp_count});
    endtask

    task automatic apply_reset(input logic [7:0] s, input logic k);
        Resetn = 1'b0;
        sw_raw = s;
        key_raw = k;
        sb.delete();
        exp_count = 4'd0;
        cycles(3);
        @(negedge Clk);
        Resetn = 1'b1;
    endtask

    task automatic press_cycle(input logic [7:0] s, input logic [7:0] exp_dout, input logic [7:0] exp_held);
        int p0;
        sw_raw = s;
        cycles(12);
        check("vec_d_out", {24'd0, d_out}, {24'd0, exp_dout});
        expect_press(exp_held);
        p0 = pulses;
        key_raw = 1'b0;
        cycles(20);
        check("vec_one_pulse", pulses, p0 + 1);
        check("vec_key_level_held", {31'd0, key_level}, 32'd1);
        key_raw = 1'b1;
        cycles(5);
        check("vec_key_level_release", {31'd0, key_level}, 32'd1);
        cycles(7);
        check("vec_key_level_idle", {31'd0, key_level}, 32'd0);
        check("vec_no_retrigger", pulses, p0 + 1);
    endtask

    initial begin
        int   p0;
        logic bad;

        vecs[0] = '{sw: 8'hA5, dout: 8'hA5, held: 8'hA5};
        vecs[1] = '{sw: 8'h00, dout: 8'h00, held: 8'h00};
        vecs[2] = '{sw: 8'hFF, dout: 8'hFF, held: 8'hFF};
        vecs[3] = '{sw: 8'h3C, dout: 8'h3C, held: 8'h3C};
        vecs[4] = '{sw: 8'h5A, dout: 8'h5A, held: 8'h5A};

        // Reset with switches high and key pressed: outputs must all be zero.
        Resetn = 1'b0;
        sw_raw = 8'hFF;
        key_raw = 1'b0;
        cycles(3);
        check("rst_d_out", {24'd0, d_out}, 32'd0);
        check("rst_load_pulse", {31'd0, load_pulse}, 32'd0);
        check("rst_held_q", {24'd0, held_q}, 32'd0);
        check("rst_press_count", {28'd0, press_count}, 32'd0);
        check("rst_key_level", {31'd0, key_level}, 32'd0);
        expect_press(8'h00);
        @(negedge Clk);
        Resetn = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(posedge Clk);
            #1;
            check($sformatf("rst_arm_pulse_c%0d", i), {31'd0, load_pulse}, (i == 7) ? 32'd1 : 32'd0);
        end
        cycles(1);
        check("rst_d_out_ff", {24'd0, d_out}, 32'hFF);
        key_raw = 1'b1;
        cycles(12);
        check("rst_key_idle", {31'd0, key_level}, 32'd0);

        // Press lands on the same edge that d_out updates: snapshot the old value.
        apply_reset(8'hFF, 1'b1);
        expect_press(8'h00);
        cycles(1);
        key_raw = 1'b0;
        for (int i = 2; i <= 8; i++) begin
            @(posedge Clk);
            #1;
            check($sformatf("coinc_pulse_c%0d", i), {31'd0, load_pulse}, (i == 8) ? 32'd1 : 32'd0);
        end
        check("coinc_d_out", {24'd0, d_out}, 32'hFF);
        check("coinc_held_q", {24'd0, held_q}, 32'h00);
        key_raw = 1'b1;
        cycles(12);

        // Table of clean presses.
        apply_reset(8'h00, 1'b1);
        cycles(2);
        for (int unsigned v = 0; v < 5; v++) begin
            press_cycle(vecs[v].sw, vecs[v].dout, vecs[v].held);
        end

        // Key bounce: no pulse while bouncing, one pulse after a stable window.
        p0 = pulses;
        expect_press(8'h5A);
        for (int i = 0; i < 3; i++) begin
            key_raw = 1'b0;
            cycles(2);
            key_raw = 1'b1;
            cycles(2);
        end
        check("bounce_no_pulse", pulses, p0);
        key_raw = 1'b0;
        cycles(6);
        check("bounce_not_early", pulses, p0);
        cycles(2);
        check("bounce_one_pulse", pulses, p0 + 1);
        cycles(12);
        key_raw = 1'b1;
        cycles(12);
        check("bounce_no_retrigger", pulses, p0 + 1);

        // Switch glitch shorter than a tick period.
        sw_raw = 8'h00;
        cycles(12);
        check("glitch_base", {24'd0, d_out}, 32'h00);
        sw_raw = 8'h01;
        cycles(3);
        sw_raw = 8'h00;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycles(1);
            if (d_out !== 8'h00) bad = 1'b1;
        end
        check("glitch_rejected", {31'd0, bad}, 32'd0);
        sw_raw = 8'h3C;
        cycles(10);
        check("glitch_held_3c", {24'd0, d_out}, 32'h3C);

        // Counter wrap over 17 presses.
        apply_reset(8'h00, 1'b1);
        cycles(2);
        for (int i = 0; i < 17; i++) begin
            press_cycle(8'(i * 37 + 1), 8'(i * 37 + 1), 8'(i * 37 + 1));
        end
        check("wrap_press_count", {28'd0, press_count}, 32'd1);

        // Reset while ARM is mid-count.
        p0 = pulses;
        key_raw = 1'b0;
        cycles(5);
        check("midrst_arm_level", {31'd0, key_level}, 32'd0);
        check("midrst_no_pulse_before", pulses, p0);
        Resetn = 1'b0;
        key_raw = 1'b1;
        sb.delete();
        exp_count = 4'd0;
        #1;
        check("midrst_d_out", {24'd0, d_out}, 32'd0);
        check("midrst_held_q", {24'd0, held_q}, 32'd0);
        check("midrst_press_count", {28'd0, press_count}, 32'd0);
        check("midrst_key_level", {31'd0, key_level}, 32'd0);
        check("midrst_load_pulse", {31'd0, load_pulse}, 32'd0);
        cycles(3);
        @(negedge Clk);
        Resetn = 1'b1;
        cycles(15);
        check("midrst_no_pulse_after", pulses, p0);
        check("midrst_press_count_after", {28'd0, press_count}, 32'd0);

        check("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/sw_key_conditioner.md
# sw_key_conditioner

Input-conditioning stage that sits directly upstream of the gated D latch and the flip-flop/register stages on the board. It synchronises and debounces the raw slide switches and one active-low pushbutton. It drives clean data levels onto the latch D inputs and produces a single-cycle load strobe per genuine key press. It also holds a snapshot register of the switch value taken at each press, so downstream storage elements never see metastable or bouncing inputs.

## Interface
Parameters:
- N, 8, number of switch channels conditioned.
- DEBOUNCE_CYCLES, 500000, stability window in Clk cycles (10 ms at 50 MHz); legal range ≥ 2.
- CNT_W, 20, width of the debounce counters; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- Clk  in  1  single system clock; all state updates on rising edge.
- Resetn  in  1  reset, asynchronous assert, active-low.
- sw_raw  in  N  raw slide switches, asynchronous to Clk.
- key_raw  in  1  raw pushbutton, asynchronous, active-low (0 = pressed).
- d_out  out  N  debounced switch levels, fed to latch D / register data.
- load_pulse  out  1  one-Clk strobe per debounced press; used as latch/register enable.
- held_q  out  N  d_out value captured on each load_pulse.
- press_count  out  4  number of debounced presses, modulo 16.
- key_level  out  1  debounced key state, active-high (1 = held).

## Operation
- Synchroniser: two-flop chain on every sw_raw bit and on key_raw.
  - sw chain resets to 0.
  - key chain resets to 1 (released).
  - Synchronised signals are sw_s and key_s.
- Switch debounce:
  - A shared tick counter counts 0..DEBOUNCE_CYCLES-1 and wraps.
  - tick is high for one cycle at the wrap.
  - On each tick: snap <= sw_s.
  - On each tick, if sw_s == snap (the old value), then d_out <= sw_s.
  - A change is therefore accepted only after surviving two consecutive ticks.
  - Glitches shorter than one tick period never reach d_out.
- Key FSM, with states IDLE, ARM, PRESSED, RELEASE and its own counter kcnt:
  - IDLE: key_s == 0 → ARM, kcnt <= 0.
  - ARM: key_s == 1 → IDLE. Otherwise kcnt increments. At kcnt == DEBOUNCE_CYCLES-1 → PRESSED, and on that transition edge:
    - load_pulse = 1;
    - held_q <= d_out;
    - press_count <= press_count + 1, wrapping 15 → 0.
  - PRESSED: key_s == 1 → RELEASE, kcnt <= 0.
  - RELEASE: key_s == 0 → PRESSED with no new pulse. Otherwise kcnt increments. At kcnt == DEBOUNCE_CYCLES-1 → IDLE.
  - key_level = 1 in PRESSED and RELEASE; 0 in IDLE and ARM.
- Simultaneous events:
  - If a d_out update and the ARM → PRESSED transition fall in the same cycle, held_q captures the pre-update d_out (the registered value).
  - A held key never re-triggers; exactly one load_pulse per press/release cycle.
- Reset mid-operation: any state, any counter value → IDLE, counters 0, all outputs 0, with no pulse emitted on reset release.

## Timing
- Reset values: d_out = 0, load_pulse = 0, held_q = 0, press_count = 0, key_level = 0, FSM = IDLE.
- Key latency, from a clean key_raw fall to load_pulse high: 2 sync cycles + 1 (IDLE → ARM) + DEBOUNCE_CYCLES cycles.
- load_pulse is exactly one cycle wide. held_q and press_count update on the same edge that raises load_pulse.
- Switch latency, from a stable sw_raw change to d_out change: between DEBOUNCE_CYCLES+2 and 2·DEBOUNCE_CYCLES+2 cycles, depending on tick phase.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package sw_cond_pkg holds:
  - the key FSM state enum (IDLE, ARM, PRESSED, RELEASE);
  - the 50 MHz default DEBOUNCE_CYCLES constant;
  - a reduced constant SIM_DEBOUNCE = 4 used by benches.
- One sub-module is natural: sync2, a parameterised-width two-flop synchroniser with a per-instance reset value. It is instantiated twice, once for sw (reset 0) and once for key (reset 1).
- Tick counter, snap/d_out logic, key FSM and capture registers stay in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset: hold Resetn = 0 with sw_raw = 8'hFF and key_raw = 0 → all outputs 0. After release with key still low → first load_pulse only after the full ARM window.
- Clean press: sw_raw = 8'hA5 stable long enough that d_out = 8'hA5, then key_raw low for 20 cycles → exactly one load_pulse; held_q = 8'hA5; press_count = 1; key_level high until 4+ cycles after release.
- Key bounce: key_raw toggles every 2 cycles for 12 cycles, then stays low → no pulse during bouncing, exactly one pulse after 4 stable cycles.
- Switch glitch: sw_raw 8'h00 → 8'h01 for 3 cycles → back to 8'h00 → d_out stays 8'h00; a held 8'h3C appears on d_out within 10 cycles.
- Wrap: 17 clean presses → press_count sequence ends at 1 (15 → 0 → 1).
- Mid-operation reset: assert Resetn = 0 while in ARM with kcnt = 2 → FSM returns to IDLE; no load_pulse before or after reset release.
